load_store_unit: RTL and testbench

//  Multi-cycle data-memory interface between the processor datapath (ALU address, rt store data,

---
 rtl/load_store_unit_pkg.sv | 14 +
 rtl/load_store_unit_align.sv | 56 +++++
 rtl/load_store_unit.sv | 133 +++++++++++++
 tb/tb_load_store_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
package load_store_unit_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/load_store_unit_align.sv
// Lane logic (combinational, zero latency): byte enables, store-lane replication and
// misalignment for the store side; lane extraction and sign/zero extension for loads.
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misaligned,
    input  logic [31:0] i_bus_rdata,
    input  logic [1:0]  i_ld_size,
    input  logic [1:0]  i_ld_off,
    input  logic        i_ld_uns,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_be         = 4'b0000;
        o_wdata      = 32'h0;
        o_misaligned = 1'b0;
        case (i_size)
            SIZE_BYTE: begin
                o_be    = 4'b0001 << i_off;
                o_wdata = {4{i_wdata[7:0]}};
            end
            SIZE_HALF: begin
                o_be         = i_off[1] ? 4'b1100 : 4'b0011;
                o_wdata      = {2{i_wdata[15:0]}};
                o_misaligned = i_off[0];
            end
            SIZE_WORD: begin
                o_be         = 4'b1111;
                o_wdata      = i_wdata;
                o_misaligned = |i_off;
            end
            default: o_misaligned = 1'b1;
        endcase
    end

    always_comb begin
        w_byte  = i_bus_rdata[{i_ld_off, 3'b000} +: 8];
        w_half  = i_ld_off[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
        o_rdata = i_bus_rdata;
        case (i_ld_size)
            SIZE_BYTE: o_rdata = {{24{w_byte[7] & ~i_ld_uns}}, w_byte};
            SIZE_HALF: o_rdata = {{16{w_half[15] & ~i_ld_uns}}, w_half};
            default:   o_rdata = i_bus_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory interface: IDLE -> REQ (held until ack or timeout) -> DONE; 3 cycles at zero wait,
// +1 per wait state. Core is stalled combinationally until DONE; bus_req never drops before ack/timeout.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_size,
    input  logic        i_load_uns,
    output logic [31:0] o_rdata,
    output logic        o_stall,
    output logic        o_misaligned,
    output logic        o_bus_error,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    lsu_state_t  r_state, w_next;
    logic [7:0]  r_cnt;
    logic [31:0] r_rdata, r_bus_addr, r_bus_wdata;
    logic [3:0]  r_bus_be;
    logic        r_bus_req, r_bus_we, r_misaligned, r_bus_error;
    logic [1:0]  r_ld_size, r_ld_off;
    logic        r_ld_uns;

    logic        w_req, w_misaligned, w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_ld_rdata;

    assign w_req     = i_mem_read | i_mem_write;
    assign w_timeout = (r_cnt == 8'(TIMEOUT_CYCLES - 1));

    load_store_unit_align u_align (
        .i_size       (i_size),
        .i_off        (i_addr[1:0]),
        .i_wdata      (i_wdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_misaligned (w_misaligned),
        .i_bus_rdata  (i_bus_rdata),
        .i_ld_size    (r_ld_size),
        .i_ld_off     (r_ld_off),
        .i_ld_uns     (r_ld_uns),
        .o_rdata      (w_ld_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_req) w_next = w_misaligned ? ST_DONE : ST_REQ;
            ST_REQ:  if (i_bus_ack || w_timeout) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt        <= 8'd0;
            r_rdata      <= 32'h0;
            r_bus_req    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_addr   <= 32'h0;
            r_bus_be     <= 4'b0000;
            r_bus_wdata  <= 32'h0;
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
            r_ld_size    <= SIZE_WORD;
            r_ld_off     <= 2'b00;
            r_ld_uns     <= 1'b0;
        end else begin
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req && w_misaligned) begin
                        r_misaligned <= 1'b1;
                    end else if (w_req) begin
                        // Simultaneous read and write resolves to a write.
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= i_mem_write;
                        r_bus_addr  <= {i_addr[31:2], 2'b00};
                        r_bus_be    <= w_be;
                        r_bus_wdata <= w_wdata;
                        r_ld_size   <= i_size;
                        r_ld_off    <= i_addr[1:0];
                        r_ld_uns    <= i_load_uns;
                    end
                end
                ST_REQ: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (i_bus_ack) begin
                        r_bus_req <= 1'b0;
                        if (!r_bus_we) r_rdata <= w_ld_rdata;
                    end else if (w_timeout) begin
                        r_bus_req   <= 1'b0;
                        r_bus_error <= 1'b1;
                        r_rdata     <= 32'h0;
                    end
                end
                ST_DONE: r_cnt <= 8'd0;
                default: r_cnt <= 8'd0;
            endcase
        end
    end

    assign o_stall      = w_req & (r_state != ST_DONE);
    assign o_rdata      = r_rdata;
    assign o_misaligned = r_misaligned;
    assign o_bus_error  = r_bus_error;
    assign o_bus_req    = r_bus_req;
    assign o_bus_we     = r_bus_we;
    assign o_bus_addr   = r_bus_addr;
    assign o_bus_be     = r_bus_be;
    assign o_bus_wdata  = r_bus_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a per-access reference model and a bus slave with wait states.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write, load_uns;
    logic [31:0] addr, wdata;
    logic [1:0]  size;
    logic [31:0] o_rdata, o_bus_addr, o_bus_wdata;
    logic        o_stall, o_misaligned, o_bus_error, o_bus_req, o_bus_we;
    logic [3:0]  o_bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_mem_read   (mem_read),
        .i_mem_write  (mem_write),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .i_size       (size),
        .i_load_uns   (load_uns),
        .o_rdata      (o_rdata),
        .o_stall      (o_stall),
        .o_misaligned (o_misaligned),
        .o_bus_error  (o_bus_error),
        .o_bus_req    (o_bus_req),
        .o_bus_we     (o_bus_we),
        .o_bus_addr   (o_bus_addr),
        .o_bus_be     (o_bus_be),
        .o_bus_wdata  (o_bus_wdata),
        .i_bus_ack    (bus_ack),
        .i_bus_rdata  (bus_rdata)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
        end
    endtask

    // Reference expectations for the access in flight.
    logic [31:0] e_addr, e_wdata, e_rdata, model_rdata;
    logic [3:0]  e_be;
    logic        e_we, e_mis, e_err;
    bit          active, saw_req;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we, cap_mis, cap_err;

    int          sl_waits, sl_cnt;
    bit          sl_never;
    logic [31:0] sl_word;

    // Bus slave: acks after sl_waits wait states, or never.
    always @(posedge clk) begin
        #1;
        if (!rst_n || !o_bus_req || sl_never) begin
            bus_ack = 1'b0;
            sl_cnt  = 0;
        end else if (sl_cnt >= sl_waits) begin
            bus_ack   = 1'b1;
            bus_rdata = sl_word;
        end else begin
            sl_cnt++;
            bus_ack = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && active) begin
            if (o_bus_req) begin
                saw_req = 1'b1;
                chk("bus_addr", o_bus_addr, e_addr);
                chk("bus_be", {28'h0, o_bus_be}, {28'h0, e_be});
                chk("bus_we", {31'h0, o_bus_we}, {31'h0, e_we});
                if (e_we) chk("bus_wdata", o_bus_wdata, e_wdata);
                cap_addr  = o_bus_addr;
                cap_be    = o_bus_be;
                cap_we    = o_bus_we;
                cap_wdata = o_bus_wdata;
            end
            if ((mem_read || mem_write) && !o_stall) begin
                chk("done_rdata", o_rdata, e_rdata);
                chk("done_misaligned", {31'h0, o_misaligned}, {31'h0, e_mis});
                chk("done_bus_error", {31'h0, o_bus_error}, {31'h0, e_err});
                cap_mis = o_misaligned;
                cap_err = o_bus_error;
            end else begin
                chk("flag_misaligned_quiet", {31'h0, o_misaligned}, 32'h0);
                chk("flag_bus_error_quiet", {31'h0, o_bus_error}, 32'h0);
            end
        end
    end

    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sz, input bit uns, input int waits, input bit never,
                          input logic [31:0] word);
        int nb, off, cycles, exp_cyc;
        logic [31:0] val, mask;
        nb    = 1 << sz;
        off   = int'(a[1:0]);
        e_mis = (sz == 2'b11) || (off % nb != 0);
        e_we  = wr;
        e_err = never && !e_mis;
        e_addr = {a[31:2], 2'b00};
        e_be = 4'b0000;
        e_wdata = 32'h0;
        if (!e_mis) begin
            for (int k = 0; k < 4; k++) begin
                if (k >= off && k < off + nb) e_be[k] = 1'b1;
                e_wdata[8*k +: 8] = wd[8*(k % nb) +: 8];
            end
            if (!wr) begin
                if (never) begin
                    model_rdata = 32'h0;
                end else begin
                    val  = word >> (8 * off);
                    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
                    val  = val & mask;
                    if (!uns && val[8*nb-1]) val = val | ~mask;
                    model_rdata = val;
                end
            end
        end
        e_rdata = model_rdata;
        exp_cyc = e_mis ? 1 : (never ? TO + 1 : waits + 2);
        sl_waits = waits;
        sl_never = never;
        sl_word  = word;
        @(posedge clk);
        #1;
        mem_read = rd; mem_write = wr; addr = a; wdata = wd; size = sz; load_uns = uns;
        saw_req = 1'b0;
        active  = 1'b1;
        cycles  = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (o_stall) cycles++;
            else break;
        end
        chk("stall_cycles", cycles, exp_cyc);
        chk("bus_req_seen", {31'h0, saw_req}, {31'h0, !e_mis});
        @(posedge clk);
        #1;
        mem_read = 1'b0; mem_write = 1'b0;
        active = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; load_uns = 1'b0;
        addr = 32'h0; wdata = 32'h0; size = 2'b10;
        bus_ack = 1'b0; bus_rdata = 32'h0;
        sl_waits = 0; sl_never = 1'b0; sl_word = 32'h0; sl_cnt = 0;
        model_rdata = 32'h0;
        active = 1'b0; saw_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_bus_req", {31'h0, o_bus_req}, 32'h0);
        chk("rst_bus_we", {31'h0, o_bus_we}, 32'h0);
        chk("rst_bus_addr", o_bus_addr, 32'h0);
        chk("rst_bus_be", {28'h0, o_bus_be}, 32'h0);
        chk("rst_bus_wdata", o_bus_wdata, 32'h0);
        chk("rst_rdata", o_rdata, 32'h0);
        chk("rst_flags", {30'h0, o_misaligned, o_bus_error}, 32'h0);
        chk("rst_stall", {31'h0, o_stall}, 32'h0);
        rst_n = 1'b1;

        // lw 0x100, two wait states
        access(1, 0, 32'h100, 32'h0, 2'b10, 0, 2, 0, 32'hDEADBEEF);
        chk("lw_rdata_lit", o_rdata, 32'hDEADBEEF);
        chk("lw_be_lit", {28'h0, cap_be}, 32'hF);

        // lb / lbu at 0x103
        access(1, 0, 32'h103, 32'h0, 2'b00, 0, 0, 0, 32'h80112233);
        chk("lb_be_lit", {28'h0, cap_be}, 32'h8);
        chk("lb_rdata_lit", o_rdata, 32'hFFFFFF80);
        access(1, 0, 32'h103, 32'h0, 2'b00, 1, 1, 0, 32'h80112233);
        chk("lbu_rdata_lit", o_rdata, 32'h00000080);

        // sh 0xABCD at 0x206
        access(0, 1, 32'h206, 32'h0000ABCD, 2'b01, 0, 1, 0, 32'h0);
        chk("sh_we_lit", {31'h0, cap_we}, 32'h1);
        chk("sh_be_lit", {28'h0, cap_be}, 32'hC);
        chk("sh_wdata_lit", cap_wdata, 32'hABCDABCD);
        chk("sh_addr_lit", cap_addr, 32'h204);
        chk("sh_rdata_kept_lit", o_rdata, 32'h00000080);

        // misaligned word
        access(1, 0, 32'h102, 32'h0, 2'b10, 0, 0, 0, 32'h0);
        chk("mis_pulse_lit", {31'h0, cap_mis}, 32'h1);

        // halfword loads, sb, read+write collision, more misaligned shapes
        access(1, 0, 32'h102, 32'h0, 2'b01, 0, 1, 0, 32'h80011234);
        chk("lh_rdata_lit", o_rdata, 32'hFFFF8001);
        access(1, 0, 32'h100, 32'h0, 2'b01, 1, 0, 0, 32'h8001F234);
        access(1, 0, 32'h100, 32'h0, 2'b00, 0, 3, 0, 32'h1234567F);
        access(0, 1, 32'h101, 32'h0000005A, 2'b00, 0, 0, 0, 32'h0);
        chk("sb_wdata_lit", cap_wdata, 32'h5A5A5A5A);
        access(1, 1, 32'h10, 32'h12345678, 2'b10, 0, 2, 0, 32'hFFFFFFFF);
        chk("rw_is_write_lit", {31'h0, cap_we}, 32'h1);
        access(1, 0, 32'h101, 32'h0, 2'b01, 0, 0, 0, 32'h0);
        access(1, 0, 32'h100, 32'h0, 2'b11, 0, 0, 0, 32'h0);

        // timeout
        access(1, 0, 32'h180, 32'h0, 2'b10, 0, 0, 1, 32'h0);
        chk("to_err_lit", {31'h0, cap_err}, 32'h1);
        chk("to_rdata_lit", o_rdata, 32'h0);
        @(negedge clk);
        chk("to_bus_req_low", {31'h0, o_bus_req}, 32'h0);

        // reset during REQ
        sl_never = 1'b1;
        @(posedge clk);
        #1;
        mem_read = 1'b1; size = 2'b10; addr = 32'h300; load_uns = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_bus_req_high", {31'h0, o_bus_req}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_bus_req_async", {31'h0, o_bus_req}, 32'h0);
        chk("mid_flags", {30'h0, o_misaligned, o_bus_error}, 32'h0);
        mem_read = 1'b0;
        model_rdata = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        access(1, 0, 32'h400, 32'h0, 2'b10, 0, 3, 0, 32'hCAFEF00D);
        chk("post_rst_lw_lit", o_rdata, 32'hCAFEF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
